// File: rtl/branch_ctrl.sv
// Branch resolution controller: captures a BEQ/BNE, waits (bounded) for its
// operands, resolves taken/not-taken and issues a one-cycle redirect + flush.
// All outputs come from registers or from the state register alone.
module branch_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic [3:0]  br_op,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [15:0] target,
  input  logic [31:0] next_pc,
  input  logic        opnd_ready,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        err,
  output logic        busy,
  output logic [15:0] branch_cnt,
  output logic [15:0] taken_cnt
);

  localparam logic [3:0] OP_BEQ    = 4'b0100;
  localparam logic [3:0] OP_BNE    = 4'b0101;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REDIRECT} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_wait_cnt;
  logic        r_bne;
  logic [15:0] r_tgt;
  logic [31:0] r_npc;
  logic        r_err;
  logic [31:0] r_rpc;
  logic [15:0] r_bcnt, r_tcnt;

  logic        w_is_br, w_accept, w_resolve, w_taken, w_timeout, w_bne, w_eq;
  logic [15:0] w_tgt;
  logic [31:0] w_base, w_offset, w_target_pc;

  // In IDLE the branch resolves straight from the ports; in WAIT from the capture.
  assign w_is_br     = br_valid && (br_op == OP_BEQ || br_op == OP_BNE);
  assign w_accept    = (r_state == S_IDLE) && w_is_br;
  assign w_resolve   = opnd_ready && (w_accept || r_state == S_WAIT);
  assign w_bne       = (r_state == S_IDLE) ? (br_op == OP_BNE) : r_bne;
  assign w_eq        = (data1 == data2);
  assign w_taken     = w_resolve && (w_bne ? !w_eq : w_eq);
  assign w_timeout   = (r_state == S_WAIT) && !opnd_ready && (r_wait_cnt == WAIT_LAST);
  assign w_base      = (r_state == S_IDLE) ? next_pc : r_npc;
  assign w_tgt       = (r_state == S_IDLE) ? target  : r_tgt;
  assign w_offset    = {{14{w_tgt[15]}}, w_tgt, 2'b00};
  assign w_target_pc = w_base + w_offset;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; resolution wins over timeout in WAIT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (opnd_ready) w_next = w_taken ? S_REDIRECT : S_IDLE;
          else            w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (opnd_ready)     w_next = w_taken ? S_REDIRECT : S_IDLE;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_REDIRECT: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Capture the branch fields when it is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bne <= (br_op == OP_BNE);
      r_tgt <= target;
      r_npc <= next_pc;
    end
  end

  // Operand-wait counter: cleared on accept, counts cycles spent waiting.
  always_ff @(posedge clk) begin
    if (!rst_n)                                                 r_wait_cnt <= '0;
    else if (w_accept)                                          r_wait_cnt <= '0;
    else if (r_state == S_WAIT && !opnd_ready && !w_timeout)    r_wait_cnt <= r_wait_cnt + 8'd1;
  end

  // Timeout pulse, redirect address and statistics counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err  <= 1'b0;
      r_rpc  <= '0;
      r_bcnt <= '0;
      r_tcnt <= '0;
    end else begin
      r_err <= w_timeout;
      if (w_resolve) r_bcnt <= r_bcnt + 16'd1;
      if (w_taken) begin
        r_tcnt <= r_tcnt + 16'd1;
        r_rpc  <= w_target_pc;
      end
    end
  end

  assign stall          = (r_state == S_WAIT);
  assign busy           = (r_state != S_IDLE);
  assign redirect_valid = (r_state == S_REDIRECT);
  assign flush          = (r_state == S_REDIRECT);
  assign err            = r_err;
  assign redirect_pc    = r_rpc;
  assign branch_cnt     = r_bcnt;
  assign taken_cnt      = r_tcnt;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed vector table, multi-cycle
// corner sequences and randomized traffic against a behavioural model.
module tb_branch_ctrl;
  localparam int WMAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, br_valid, opnd_ready;
  logic [3:0]  br_op;
  logic [31:0] data1, data2, next_pc;
  logic [15:0] target;
  logic        stall, redirect_valid, flush, err, busy;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt, taken_cnt;

  branch_ctrl #(.WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_op(br_op),
    .data1(data1), .data2(data2), .target(target), .next_pc(next_pc),
    .opnd_ready(opnd_ready), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .err(err), .busy(busy),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: a pending branch, how long it has waited, and
  // whether a redirect is being shown this cycle.
  bit          m_pend, m_redir, m_err, m_pend_bne;
  logic [31:0] m_pend_pc, m_rpc;
  int          m_waited, m_bc, m_tc;

  function automatic logic [31:0] tgt_addr(logic [31:0] pc, logic [15:0] off);
    return pc + 32'(int'($signed(off)) * 4);
  endfunction

  task automatic m_resolve(bit bne, logic [31:0] pc_t);
    bit tk;
    tk = bne ? (data1 != data2) : (data1 == data2);
    m_bc = (m_bc + 1) % 65536;
    if (tk) begin
      m_tc    = (m_tc + 1) % 65536;
      m_rpc   = pc_t;
      m_redir = 1'b1;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_pend = 0; m_redir = 0; m_err = 0; m_waited = 0;
      m_rpc = '0; m_bc = 0; m_tc = 0;
      return;
    end
    m_err = 1'b0;
    if (m_redir) m_redir = 1'b0;
    else if (m_pend) begin
      if (opnd_ready) begin
        m_pend = 1'b0;
        m_resolve(m_pend_bne, m_pend_pc);
      end else if (m_waited == WMAX - 1) begin
        m_pend = 1'b0;
        m_err  = 1'b1;
      end else m_waited++;
    end else if (br_valid && (br_op == 4'b0100 || br_op == 4'b0101)) begin
      if (opnd_ready) m_resolve(br_op == 4'b0101, tgt_addr(next_pc, target));
      else begin
        m_pend     = 1'b1;
        m_waited   = 0;
        m_pend_bne = (br_op == 4'b0101);
        m_pend_pc  = tgt_addr(next_pc, target);
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_stall", 32'(stall), 32'(m_pend));
    chk("m_busy", 32'(busy), 32'(m_pend || m_redir));
    chk("m_redirect_valid", 32'(redirect_valid), 32'(m_redir));
    chk("m_flush", 32'(flush), 32'(m_redir));
    chk("m_err", 32'(err), 32'(m_err));
    chk("m_redirect_pc", redirect_pc, m_rpc);
    chk("m_branch_cnt", 32'(branch_cnt), 32'(m_bc[15:0]));
    chk("m_taken_cnt", 32'(taken_cnt), 32'(m_tc[15:0]));
  endtask

  // One clock: model consumes the current inputs, DUT samples them, then compare.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_in();
    br_valid = 0; br_op = 4'h0; opnd_ready = 0;
  endtask

  task automatic present(logic [3:0] op, logic [31:0] d1, logic [31:0] d2,
                         logic [15:0] tg, logic [31:0] pc, logic rdy);
    br_valid = 1; br_op = op; data1 = d1; data2 = d2;
    target = tg; next_pc = pc; opnd_ready = rdy;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d1, d2;
    logic [15:0] tg;
    logic [31:0] pc;
    bit          taken;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int sc, b0, t0, tk_sum;

    tbl[0] = '{4'b0100, 32'h1,        32'h1,        16'h0001, 32'h4,        1'b1, 32'h8};
    tbl[1] = '{4'b0100, 32'h1,        32'h10,       16'h0001, 32'h4,        1'b0, 32'h0};
    tbl[2] = '{4'b0101, 32'h1,        32'h10,       16'hFFFE, 32'h100,      1'b1, 32'hF8};
    tbl[3] = '{4'b0101, 32'h5,        32'h5,        16'h0010, 32'h40,       1'b0, 32'h0};
    tbl[4] = '{4'b0100, 32'h0,        32'h0,        16'h7FFF, 32'h0,        1'b1, 32'h1FFFC};
    tbl[5] = '{4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h8000, 32'h10,       1'b1, 32'hFFFE0010};
    tbl[6] = '{4'b0101, 32'h80000000, 32'h0,        16'hFFFF, 32'h0,        1'b1, 32'hFFFFFFFC};
    tbl[7] = '{4'b0101, 32'h1,        32'h2,        16'h0001, 32'hFFFFFFFC, 1'b1, 32'h0};

    rst_n = 0; data1 = 0; data2 = 0; target = 0; next_pc = 0;
    idle_in();
    tick();
    tick();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_redirect_valid", 32'(redirect_valid), 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_branch_cnt", 32'(branch_cnt), 0);
    rst_n = 1;
    tick();

    // Directed single-cycle resolutions from IDLE
    tk_sum = 0;
    for (int i = 0; i < 8; i++) begin
      present(tbl[i].op, tbl[i].d1, tbl[i].d2, tbl[i].tg, tbl[i].pc, 1'b1);
      tick();
      tk_sum += int'(tbl[i].taken);
      chk($sformatf("tbl%0d_redirect_valid", i), 32'(redirect_valid), 32'(tbl[i].taken));
      chk($sformatf("tbl%0d_flush", i), 32'(flush), 32'(tbl[i].taken));
      if (tbl[i].taken) chk($sformatf("tbl%0d_redirect_pc", i), redirect_pc, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_branch_cnt", i), 32'(branch_cnt), 32'(i + 1));
      chk($sformatf("tbl%0d_taken_cnt", i), 32'(taken_cnt), 32'(tk_sum));
      idle_in();
      tick();
      chk($sformatf("tbl%0d_after_rv", i), 32'(redirect_valid), 0);
    end

    // Operands arrive after three waiting cycles
    sc = 0;
    present(4'b0100, 32'h7, 32'h7, 16'h0004, 32'h200, 1'b0);
    tick();
    if (stall) sc++;
    br_valid = 0;
    repeat (2) begin
      tick();
      if (stall) sc++;
    end
    opnd_ready = 1;
    tick();
    chk("wait3_stall_cycles", 32'(sc), 3);
    chk("wait3_stall_low", 32'(stall), 0);
    chk("wait3_redirect_valid", 32'(redirect_valid), 1);
    chk("wait3_redirect_pc", redirect_pc, 32'h210);
    idle_in();
    tick();

    // Timeout with operands never ready
    b0 = m_bc; t0 = m_tc;
    present(4'b0100, 32'h3, 32'h3, 16'h0008, 32'h300, 1'b0);
    tick();
    br_valid = 0;
    sc = 0;
    for (int k = 0; k < 40 && stall; k++) begin
      sc++;
      tick();
    end
    chk("tmo_stall_cycles", 32'(sc), 32'(WMAX));
    chk("tmo_err", 32'(err), 1);
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_redirect_valid", 32'(redirect_valid), 0);
    chk("tmo_branch_cnt", 32'(branch_cnt), 32'(b0));
    chk("tmo_taken_cnt", 32'(taken_cnt), 32'(t0));
    tick();
    chk("tmo_err_pulse", 32'(err), 0);

    // Operands arrive on the last WAIT cycle: resolution beats timeout
    present(4'b0101, 32'h1, 32'h2, 16'h0002, 32'h400, 1'b0);
    tick();
    br_valid = 0;
    repeat (WMAX - 1) tick();
    chk("late_still_stall", 32'(stall), 1);
    opnd_ready = 1;
    tick();
    chk("late_err", 32'(err), 0);
    chk("late_redirect_valid", 32'(redirect_valid), 1);
    chk("late_redirect_pc", redirect_pc, 32'h408);
    idle_in();
    tick();

    // Reset while waiting aborts the branch
    present(4'b0100, 32'h9, 32'h9, 16'h0001, 32'h500, 1'b0);
    tick();
    br_valid = 0;
    tick();
    rst_n = 0;
    tick();
    chk("rstw_stall", 32'(stall), 0);
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_err", 32'(err), 0);
    chk("rstw_flush", 32'(flush), 0);
    chk("rstw_branch_cnt", 32'(branch_cnt), 0);
    chk("rstw_taken_cnt", 32'(taken_cnt), 0);
    rst_n = 1;
    opnd_ready = 1;
    tick();
    chk("rstw_no_redirect", 32'(redirect_valid), 0);
    chk("rstw_cnt_hold", 32'(branch_cnt), 0);
    idle_in();
    tick();

    // Invalid opcode is ignored
    present(4'b0011, 32'h5, 32'h5, 16'h0001, 32'h600, 1'b1);
    tick();
    chk("inv_busy", 32'(busy), 0);
    chk("inv_redirect_valid", 32'(redirect_valid), 0);
    chk("inv_branch_cnt", 32'(branch_cnt), 0);

    // A branch presented during REDIRECT is ignored
    present(4'b0100, 32'h5, 32'h5, 16'h0001, 32'h700, 1'b1);
    tick();
    present(4'b0100, 32'h6, 32'h6, 16'h0003, 32'h800, 1'b1);
    tick();
    chk("redir_ign_rv", 32'(redirect_valid), 0);
    chk("redir_ign_busy", 32'(busy), 0);
    chk("redir_ign_branch_cnt", 32'(branch_cnt), 1);
    chk("redir_ign_pc", redirect_pc, 32'h704);
    idle_in();
    tick();

    // Counter wrap: preload both counters to their maximum
    dut.r_bcnt = 16'hFFFF;
    dut.r_tcnt = 16'hFFFF;
    m_bc = 65535; m_tc = 65535;
    present(4'b0101, 32'h1, 32'h0, 16'h0001, 32'h900, 1'b1);
    tick();
    chk("wrap_taken_cnt", 32'(taken_cnt), 0);
    chk("wrap_branch_cnt", 32'(branch_cnt), 0);
    idle_in();
    tick();

    // Randomized traffic against the model; second half favours timeouts
    for (int c = 0; c < 800; c++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      br_valid   = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0, 1:    br_op = 4'b0100;
        2, 3:    br_op = 4'b0101;
        4:       br_op = 4'b0011;
        default: br_op = 4'($urandom);
      endcase
      data1      = $urandom_range(0, 2);
      data2      = $urandom_range(0, 2);
      target     = 16'($urandom);
      next_pc    = $urandom;
      opnd_ready = (c < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum cycles spent waiting for operands before abort (legal range 1..255).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have port br_valid  in  1  a branch instruction is presented this cycle.
REQ-005 SHALL have port br_op  in  4  branch opcode: 4'b0100 BEQ, 4'b0101 BNE; any other value is not a branch.
REQ-006 SHALL have ports data1, data2  in  32  operands compared for equality.
REQ-007 SHALL have port target  in  16  signed word offset.
REQ-008 SHALL have port next_pc  in  32  PC+4 of the branch instruction.
REQ-009 SHALL have port opnd_ready  in  1  data1 and data2 are valid (hazard/forwarding resolved).
REQ-010 SHALL have port stall  out  1  hold fetch/decode.
REQ-011 SHALL have port redirect_valid  out  1  load redirect_pc into the PC.
REQ-012 SHALL have port redirect_pc  out  32  branch target address.
REQ-013 SHALL have port flush  out  1  squash the fetched wrong-path instruction.
REQ-014 SHALL have port err  out  1  operand-wait timeout pulse.
REQ-015 SHALL have port busy  out  1  controller is not in IDLE.
REQ-016 SHALL have ports branch_cnt, taken_cnt  out  16  resolved-branch and taken-branch counters.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, REDIRECT; all outputs registered or decoded from state only, no input-to-output combinational path.
REQ-018 IDLE: br_valid=1 with a valid br_op SHALL capture br_op, target and next_pc; if opnd_ready=1, resolve the same edge, otherwise go to WAIT with wait_cnt=0.
REQ-019 IDLE: br_valid=1 with an invalid br_op SHALL be ignored (no state, counter or output change).
REQ-020 Resolution: taken = (data1==data2) for BEQ, (data1!=data2) for BNE, using data1/data2 sampled at the resolving edge.
REQ-021 Taken: go to REDIRECT; redirect_valid=1 and flush=1 for exactly the one cycle after the resolving edge.
REQ-022 Not taken: return to IDLE; no redirect or flush.
REQ-023 redirect_pc SHALL equal captured next_pc + {14 copies of target[15], target, 2'b00}, modulo 2^32; it holds its value when redirect_valid=0.
REQ-024 WAIT: stall=1 every cycle in WAIT. opnd_ready=1 resolves per REQ-020..022. opnd_ready=0 increments wait_cnt.
REQ-025 WAIT timeout: opnd_ready=0 while wait_cnt==WAIT_MAX-1 SHALL go to IDLE, with err=1 for one cycle, no redirect and no counter update; stall is high for exactly WAIT_MAX cycles.
REQ-026 If opnd_ready=1 on the timeout cycle, resolution SHALL take precedence over timeout.
REQ-027 REDIRECT SHALL last exactly one cycle, then go to IDLE; br_valid is ignored in REDIRECT and WAIT.
REQ-028 On every resolution, branch_cnt SHALL increment by 1; taken_cnt SHALL increment by 1 when taken. Both wrap 0xFFFF to 0x0000.
REQ-029 busy = (state != IDLE).
REQ-030 Resolution latency SHALL be one cycle from the resolving edge; a back-to-back branch is accepted in the first IDLE cycle.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, wait_cnt=0, and set stall, redirect_valid, flush, err, busy, redirect_pc, branch_cnt and taken_cnt to 0, overriding any in-flight WAIT or REDIRECT.
REQ-032 A branch aborted by reset SHALL produce no redirect and no counter update after reset releases.

Verification
REQ-033 BEQ, data1=data2=0x1, target=0x0001, next_pc=0x4, opnd_ready=1 -> next cycle: redirect_valid=1, flush=1, redirect_pc=0x8, branch_cnt=1, taken_cnt=1.
REQ-034 BEQ, data1=0x1, data2=0x10 -> no redirect or flush; branch_cnt=1, taken_cnt=0. Same operands with BNE, target=0xFFFE, next_pc=0x100 -> redirect_pc=0xF8.
REQ-035 BEQ taken with opnd_ready low for 3 edges then high -> stall high exactly 3 cycles, then redirect_valid=1 the cycle after stall drops.
REQ-036 WAIT_MAX=15, opnd_ready held low -> stall high 15 cycles, then err=1 for one cycle, busy=0, counters unchanged; and opnd_ready rising on the 15th WAIT cycle -> resolves, err stays 0.
REQ-037 rst_n=0 for one edge while in WAIT -> all outputs 0 next cycle; a later opnd_ready=1 causes no redirect.
REQ-038 br_op=4'b0011 with br_valid=1, and br_valid during REDIRECT -> ignored; taken_cnt wrap 0xFFFF->0x0000 checked.
